mib_master_wide: RTL and testbench

// Parametrised MIB bus master. Converts one command-bus transaction into a MIB cycle:

---
 rtl/mib_master_wide.sv | 233 +++++++++++++++++++++++
 tb/tb_mib_master_wide.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mib_master_wide.sv
// mib_master_wide: command-bus to MIB bus master, generic AD / address / data widths; retry option MIB_MASTER_RETRY_EN.
// Latency: start 1 clk after sel; NA address beats, ND data beats, ACK wait, then ack/timeout pulse on first GAP clock.
// Backpressure: i_cmd_sel sampled only in IDLE; o_busy high in all other states; sel during a cycle is ignored.
module mib_master_wide #(
   parameter int P_AD_W                 = 16,
   parameter int P_ADDR_W               = 24,
   parameter int P_DATA_W               = 32,
   parameter int P_MIB_ACK_TIMEOUT_CLKS = 32,
   parameter int P_GAP_CLKS             = 1,
   parameter int P_RETRIES              = 2
) (
   input  logic                i_sysclk,
   input  logic                i_srst,
   input  logic                i_cmd_sel,
   input  logic                i_cmd_rd_wr_n,
   input  logic [P_ADDR_W-1:0] i_cmd_byte_addr,
   input  logic [P_DATA_W-1:0] i_cmd_wdata,
   output logic [P_DATA_W-1:0] o_cmd_rdata,
   output logic                o_cmd_ack,
   output logic                o_cmd_mib_timeout,
   output logic                o_busy,
   output logic                o_mib_start,
   output logic                o_mib_rd_wr_n,
   input  logic                i_mib_slave_ack,
   input  logic [P_AD_W-1:0]   i_mib_ad,
   output logic [P_AD_W-1:0]   o_mib_ad,
   output logic                o_mib_ad_high_z
);

   localparam int LP_NA   = (P_ADDR_W + P_AD_W - 1) / P_AD_W;
   localparam int LP_ND   = P_DATA_W / P_AD_W;
   localparam int LP_AW   = LP_NA * P_AD_W;
   localparam int LP_MAXB = (LP_NA > LP_ND) ? LP_NA : LP_ND;
   localparam int LP_BW   = (LP_MAXB > 1) ? $clog2(LP_MAXB) : 1;
   localparam int LP_TW   = $clog2(P_MIB_ACK_TIMEOUT_CLKS);
   localparam int LP_GW   = (P_GAP_CLKS > 1) ? $clog2(P_GAP_CLKS) : 1;
   localparam int LP_RW   = (P_RETRIES > 0) ? $clog2(P_RETRIES + 1) : 1;

   localparam logic [LP_BW-1:0] LP_NA_LAST   = LP_BW'(LP_NA - 1);
   localparam logic [LP_BW-1:0] LP_ND_LAST   = LP_BW'(LP_ND - 1);
   localparam logic [LP_TW-1:0] LP_TMO_LAST  = LP_TW'(P_MIB_ACK_TIMEOUT_CLKS - 1);
   localparam logic [LP_GW-1:0] LP_GAP_LAST  = LP_GW'(P_GAP_CLKS - 1);
   localparam logic [LP_RW-1:0] LP_RETRY_MAX = LP_RW'(P_RETRIES);

`ifdef MIB_MASTER_RETRY_EN
   localparam bit LP_RETRY_EN = 1'b1;
`else
   localparam bit LP_RETRY_EN = 1'b0;
`endif

   generate
      if (P_DATA_W % P_AD_W != 0) begin : g_err_data_w
         $error("mib_master_wide: P_DATA_W must be a multiple of P_AD_W");
      end
      if (P_MIB_ACK_TIMEOUT_CLKS < 2) begin : g_err_tmo
         $error("mib_master_wide: P_MIB_ACK_TIMEOUT_CLKS must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WACK, S_RACK, S_RDATA, S_GAP} state_t;

   state_t              r_state,    w_state_nxt;
   logic [LP_BW-1:0]    r_beat,     w_beat_nxt;
   logic [LP_TW-1:0]    r_tmo_cnt,  w_tmo_cnt_nxt;
   logic [LP_GW-1:0]    r_gap_cnt,  w_gap_cnt_nxt;
   logic [LP_RW-1:0]    r_retry,    w_retry_nxt;
   logic                r_tmo_flag, w_tmo_flag_nxt;

   logic                w_cmd_load, w_sh_reload, w_addr_shift, w_wdata_shift, w_rd_cap;
   logic                w_retry_pend, w_gap_first;

   logic [LP_AW-1:0]    r_addr, r_addr_sh;
   logic [P_DATA_W-1:0] r_wdata, r_wdata_sh, r_rdata;
   logic                r_rd_wr_n, r_ack_q;
   logic [P_AD_W-1:0]   r_ad_q;

   // A timed-out cycle is re-issued only while retries remain and the option is built in.
   assign w_retry_pend = LP_RETRY_EN && r_tmo_flag && (r_retry != LP_RETRY_MAX);
   assign w_gap_first  = (r_state == S_GAP) && (r_gap_cnt == '0);

   // State register and cycle counters; reset aborts any cycle in progress.
   always_ff @(posedge i_sysclk or posedge i_srst) begin
      if (i_srst) begin
         r_state    <= S_IDLE;
         r_beat     <= '0;
         r_tmo_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_retry    <= '0;
         r_tmo_flag <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat     <= w_beat_nxt;
         r_tmo_cnt  <= w_tmo_cnt_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
         r_retry    <= w_retry_nxt;
         r_tmo_flag <= w_tmo_flag_nxt;
      end
   end

   // Next-state, counter updates and datapath strobes.
   always_comb begin
      w_state_nxt    = r_state;
      w_beat_nxt     = r_beat;
      w_tmo_cnt_nxt  = r_tmo_cnt;
      w_gap_cnt_nxt  = r_gap_cnt;
      w_retry_nxt    = r_retry;
      w_tmo_flag_nxt = r_tmo_flag;
      w_cmd_load     = 1'b0;
      w_sh_reload    = 1'b0;
      w_addr_shift   = 1'b0;
      w_wdata_shift  = 1'b0;
      w_rd_cap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_cmd_sel) begin
               w_cmd_load     = 1'b1;
               w_state_nxt    = S_ADDR;
               w_beat_nxt     = '0;
               w_retry_nxt    = '0;
               w_tmo_flag_nxt = 1'b0;
            end
         end
         S_ADDR: begin
            if (r_beat == LP_NA_LAST) begin
               w_beat_nxt    = '0;
               w_tmo_cnt_nxt = '0;
               w_state_nxt   = r_rd_wr_n ? S_RACK : S_WDATA;
            end else begin
               w_beat_nxt   = r_beat + LP_BW'(1);
               w_addr_shift = 1'b1;
            end
         end
         S_WDATA: begin
            if (r_beat == LP_ND_LAST) begin
               w_beat_nxt    = '0;
               w_tmo_cnt_nxt = '0;
               w_state_nxt   = S_WACK;
            end else begin
               w_beat_nxt    = r_beat + LP_BW'(1);
               w_wdata_shift = 1'b1;
            end
         end
         S_WACK, S_RACK: begin
            // ACK is checked first so an ACK on the expiry clock still completes the cycle.
            if (r_ack_q) begin
               w_tmo_flag_nxt = 1'b0;
               w_gap_cnt_nxt  = '0;
               w_state_nxt    = S_GAP;
               if (r_state == S_RACK) begin
                  w_rd_cap = 1'b1;
                  if (LP_ND > 1) begin
                     w_beat_nxt  = LP_BW'(1);
                     w_state_nxt = S_RDATA;
                  end
               end
            end else if (r_tmo_cnt == LP_TMO_LAST) begin
               w_tmo_flag_nxt = 1'b1;
               w_gap_cnt_nxt  = '0;
               w_state_nxt    = S_GAP;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + LP_TW'(1);
            end
         end
         S_RDATA: begin
            w_rd_cap = 1'b1;
            if (r_beat == LP_ND_LAST) begin
               w_gap_cnt_nxt = '0;
               w_state_nxt   = S_GAP;
            end else begin
               w_beat_nxt = r_beat + LP_BW'(1);
            end
         end
         S_GAP: begin
            if (r_gap_cnt == LP_GAP_LAST) begin
               if (w_retry_pend) begin
                  w_sh_reload    = 1'b1;
                  w_retry_nxt    = r_retry + LP_RW'(1);
                  w_tmo_flag_nxt = 1'b0;
                  w_beat_nxt     = '0;
                  w_state_nxt    = S_ADDR;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + LP_GW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Command capture, beat shifters, read-data assembly and input registering.
   always_ff @(posedge i_sysclk or posedge i_srst) begin
      if (i_srst) begin
         r_addr     <= '0;
         r_addr_sh  <= '0;
         r_wdata    <= '0;
         r_wdata_sh <= '0;
         r_rdata    <= '0;
         r_rd_wr_n  <= 1'b1;
         r_ack_q    <= 1'b0;
         r_ad_q     <= '0;
      end else begin
         r_ack_q <= i_mib_slave_ack;
         r_ad_q  <= i_mib_ad;
         if (w_cmd_load) begin
            r_addr     <= LP_AW'(i_cmd_byte_addr);
            r_addr_sh  <= LP_AW'(i_cmd_byte_addr);
            r_wdata    <= i_cmd_wdata;
            r_wdata_sh <= i_cmd_wdata;
            r_rd_wr_n  <= i_cmd_rd_wr_n;
         end else if (w_sh_reload) begin
            r_addr_sh  <= r_addr;
            r_wdata_sh <= r_wdata;
         end else begin
            if (w_addr_shift)  r_addr_sh  <= r_addr_sh << P_AD_W;
            if (w_wdata_shift) r_wdata_sh <= r_wdata_sh << P_AD_W;
         end
         if (w_rd_cap) r_rdata <= (r_rdata << P_AD_W) | P_DATA_W'(r_ad_q);
      end
   end

   assign o_busy            = (r_state != S_IDLE);
   assign o_mib_start       = (r_state == S_ADDR) && (r_beat == '0);
   assign o_mib_ad_high_z   = !((r_state == S_ADDR) || (r_state == S_WDATA));
   assign o_mib_ad          = (r_state == S_ADDR)  ? r_addr_sh[LP_AW-1 -: P_AD_W] :
                              (r_state == S_WDATA) ? r_wdata_sh[P_DATA_W-1 -: P_AD_W] : '0;
   assign o_mib_rd_wr_n     = r_rd_wr_n;
   assign o_cmd_rdata       = r_rdata;
   assign o_cmd_ack         = w_gap_first && !r_tmo_flag;
   assign o_cmd_mib_timeout = w_gap_first && r_tmo_flag && !w_retry_pend;

endmodule

// File: tb/tb_mib_master_wide.sv
// tb_mib_master_wide: table-driven scoreboard bench for mib_master_wide (default and 40/64-bit builds).
// Latency: beats and completion pulses are checked at the negedge they appear.
// Backpressure: slave ACK is modelled per vector; bounded waits report a FAIL instead of hanging.
module tb_mib_master_wide;

`ifdef MIB_MASTER_RETRY_EN
   localparam int TB_TRIES   = 3;
   localparam int TB_TMO_LAT = 33;
`else
   localparam int TB_TRIES   = 1;
   localparam int TB_TMO_LAT = 32;
`endif

   typedef struct packed {
      logic        rd;
      logic [23:0] addr;
      logic [31:0] wdata;
      int          ack_try;
      int          ack_dly;
      bit          meas;
      logic [15:0] rd_hi;
      logic [15:0] rd_lo;
      int          nb;
      logic [63:0] beats;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct packed {logic start; logic rdwr; logic [15:0] ad;} beat_t;
   typedef struct packed {logic tmo; logic [31:0] rdata;} done_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel, rdwr;
   logic [23:0] addr;
   logic [31:0] wdata, rdata;
   logic        ack, tmo, busy, start, mib_rdwr, slv_ack, hz;
   logic [15:0] ad_in, ad_out;

   logic        sel1, slv_ack1, ack1, tmo1, busy1, start1, mib_rdwr1, hz1;
   logic [39:0] addr1;
   logic [63:0] wdata1, rdata1;
   logic [15:0] ad_in1, ad_out1;

   int    n_chk, n_fail, n_starts;
   bit    mon_en;
   beat_t beat_q[$];
   done_t done_q[$];
   vec_t  vecs[8];
   vec_t  v6;

   always #5 clk = ~clk;

   mib_master_wide dut (
      .i_sysclk(clk), .i_srst(rst), .i_cmd_sel(sel), .i_cmd_rd_wr_n(rdwr),
      .i_cmd_byte_addr(addr), .i_cmd_wdata(wdata), .o_cmd_rdata(rdata),
      .o_cmd_ack(ack), .o_cmd_mib_timeout(tmo), .o_busy(busy), .o_mib_start(start),
      .o_mib_rd_wr_n(mib_rdwr), .i_mib_slave_ack(slv_ack), .i_mib_ad(ad_in),
      .o_mib_ad(ad_out), .o_mib_ad_high_z(hz)
   );

   mib_master_wide #(.P_ADDR_W(40), .P_DATA_W(64)) dut_w (
      .i_sysclk(clk), .i_srst(rst), .i_cmd_sel(sel1), .i_cmd_rd_wr_n(1'b0),
      .i_cmd_byte_addr(addr1), .i_cmd_wdata(wdata1), .o_cmd_rdata(rdata1),
      .o_cmd_ack(ack1), .o_cmd_mib_timeout(tmo1), .o_busy(busy1), .o_mib_start(start1),
      .o_mib_rd_wr_n(mib_rdwr1), .i_mib_slave_ack(slv_ack1), .i_mib_ad(ad_in1),
      .o_mib_ad(ad_out1), .o_mib_ad_high_z(hz1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic [23:0] a, input logic [31:0] w,
                               input int at, input int dly, input bit meas,
                               input logic [15:0] hi, input logic [15:0] lo, input int nb,
                               input logic [63:0] beats, input logic [31:0] er);
      vec_t v;
      v.rd = rd; v.addr = a; v.wdata = w; v.ack_try = at; v.ack_dly = dly; v.meas = meas;
      v.rd_hi = hi; v.rd_lo = lo; v.nb = nb; v.beats = beats; v.exp_rdata = er;
      return v;
   endfunction

   // Scoreboard monitor: every driven beat and every completion pulse is matched against the queues.
   initial forever begin
      beat_t b;
      done_t d;
      @(negedge clk);
      if (mon_en) begin
         if (start) n_starts++;
         if (!hz) begin
            if (beat_q.size() == 0) begin
               check("unexpected_beat", {47'd0, start, ad_out}, 64'h0);
            end else begin
               b = beat_q.pop_front();
               check("beat_ad", ad_out, b.ad);
               check("beat_start", start, b.start);
               check("beat_rdwr", mib_rdwr, b.rdwr);
            end
         end
         if (ack || tmo) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", {ack, tmo}, 2'b00);
            end else begin
               d = done_q.pop_front();
               check("done_ack", ack, !d.tmo);
               check("done_tmo", tmo, d.tmo);
               check("done_rdata", rdata, d.rdata);
            end
         end
      end
   end

   task automatic wait_hz(input logic val);
      int n = 0;
      @(negedge clk);
      while (hz !== val && n < 200) begin @(negedge clk); n++; end
      check("wait_high_z", hz, val);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
      check("wait_idle", busy, 1'b0);
   endtask

   task automatic slave_ack(input vec_t v);
      repeat (v.ack_dly) @(negedge clk);
      slv_ack = 1'b1; ad_in = v.rd_hi;
      @(negedge clk);
      slv_ack = 1'b0; ad_in = v.rd_lo;
      @(negedge clk);
      ad_in = '0;
   endtask

   task automatic do_cycle(input vec_t v, input bit sel_held);
      bit is_tmo;
      int n_att, cnt;
      is_tmo = (v.ack_try < 0) || (v.ack_try >= TB_TRIES);
      n_att  = is_tmo ? TB_TRIES : v.ack_try + 1;
      for (int a = 0; a < n_att; a++)
         for (int b = 0; b < v.nb; b++)
            beat_q.push_back({b == 0, v.rd, v.beats[63 - 16*b -: 16]});
      done_q.push_back({is_tmo, v.exp_rdata});
      n_starts = 0;
      if (!sel_held) @(negedge clk);
      rdwr = v.rd; addr = v.addr; wdata = v.wdata; sel = 1'b1;
      @(posedge clk); #1 sel = 1'b0;
      for (int a = 0; a < n_att; a++) begin
         wait_hz(1'b0);
         wait_hz(1'b1);
         if (v.meas && a == 0) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!tmo && !start && cnt < 100);
            check("tmo_latency", cnt, TB_TMO_LAT);
`ifndef MIB_MASTER_RETRY_EN
            @(negedge clk);
            check("busy_after_tmo", busy, 1'b0);
`endif
         end
         if (!is_tmo && a == v.ack_try) slave_ack(v);
      end
      wait_idle();
      check("start_count", n_starts, n_att);
      check("beats_left", beat_q.size(), 0);
      check("done_left", done_q.size(), 0);
   endtask

   initial begin
      logic [15:0] exp4 [7];
      int n, n_ack;
      n_chk = 0; n_fail = 0; n_starts = 0; mon_en = 1'b0;
      rst = 1'b1; sel = 0; rdwr = 0; addr = 0; wdata = 0; slv_ack = 0; ad_in = 0;
      sel1 = 0; addr1 = 0; wdata1 = 0; slv_ack1 = 0; ad_in1 = 0;

      vecs[0] = mk(1'b0, 24'h123456, 32'hDEADBEEF, 0, 3, 1'b0, 16'h0, 16'h0, 4, 64'h0012_3456_DEAD_BEEF, 32'h0);
      vecs[1] = mk(1'b1, 24'h000010, 32'h0, 0, 0, 1'b0, 16'hCAFE, 16'hF00D, 2, 64'h0000_0010_0000_0000, 32'hCAFEF00D);
      vecs[2] = mk(1'b0, 24'hFFFFFF, 32'h00000001, 0, 1, 1'b0, 16'h0, 16'h0, 4, 64'h00FF_FFFF_0000_0001, 32'hCAFEF00D);
      vecs[3] = mk(1'b1, 24'hABCDEF, 32'h0, 0, 5, 1'b0, 16'h1234, 16'h5678, 2, 64'h00AB_CDEF_0000_0000, 32'h12345678);
      vecs[4] = mk(1'b0, 24'h000002, 32'h0000FFFF, 0, 30, 1'b0, 16'h0, 16'h0, 4, 64'h0000_0002_0000_FFFF, 32'h12345678);
      vecs[5] = mk(1'b0, 24'h000100, 32'h55AA55AA, 2, 2, 1'b0, 16'h0, 16'h0, 4, 64'h0000_0100_55AA_55AA, 32'h12345678);
      vecs[6] = mk(1'b1, 24'h0000FE, 32'h0, -1, 0, 1'b0, 16'h0, 16'h0, 2, 64'h0000_00FE_0000_0000, 32'h12345678);
      vecs[7] = mk(1'b0, 24'h000040, 32'h0BAD0BAD, -1, 0, 1'b1, 16'h0, 16'h0, 4, 64'h0000_0040_0BAD_0BAD, 32'h12345678);
      v6      = mk(1'b0, 24'h654321, 32'h13572468, 0, 2, 1'b0, 16'h0, 16'h0, 4, 64'h0065_4321_1357_2468, 32'h0);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_high_z", hz, 1'b1);
      check("rst_ad", ad_out, 16'h0);
      check("rst_rdwr", mib_rdwr, 1'b1);
      check("rst_rdata", rdata, 32'h0);
      check("rst_start", start, 1'b0);
      check("rst_ack", ack, 1'b0);
      check("rst_tmo", tmo, 1'b0);
      rst = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 8; i++) do_cycle(vecs[i], 1'b0);

      // Wide build: three address beats and four data beats, one start.
      exp4 = '{16'h00AB, 16'h1234, 16'h5678, 16'h0102, 16'h0304, 16'h0506, 16'h0708};
      @(negedge clk);
      addr1 = 40'hAB_1234_5678; wdata1 = 64'h0102030405060708; sel1 = 1'b1;
      @(posedge clk); #1 sel1 = 1'b0;
      n = 0;
      @(negedge clk);
      while (hz1 && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 7; i++) begin
         check("wide_beat", ad_out1, exp4[i]);
         check("wide_start", start1, i == 0);
         @(negedge clk);
      end
      check("wide_release", hz1, 1'b1);
      slv_ack1 = 1'b1;
      n_ack = 0; n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         slv_ack1 = 1'b0;
         if (ack1) n_ack++;
         if (start1) n++;
      end
      check("wide_ack_count", n_ack, 1);
      check("wide_restart", n, 0);
      check("wide_idle", busy1, 1'b0);

      // Reset during WDATA with sel held high, then a fresh cycle after release.
      mon_en = 1'b0;
      beat_q.delete(); done_q.delete();
      @(negedge clk);
      rdwr = 1'b0; addr = 24'h654321; wdata = 32'h13572468; sel = 1'b1;
      n = 0;
      while (!start && n < 20) begin @(negedge clk); n++; end
      check("t6_start", start, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("t6_wdata0", ad_out, 16'h1357);
      rst = 1'b1;
      #1;
      check("t6_start_rst", start, 1'b0);
      check("t6_high_z", hz, 1'b1);
      check("t6_ad", ad_out, 16'h0);
      check("t6_busy", busy, 1'b0);
      check("t6_rdwr", mib_rdwr, 1'b1);
      check("t6_rdata", rdata, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_pulse", {ack, tmo, busy}, 3'b000);
      end
      mon_en = 1'b1;
      rst = 1'b0;
      do_cycle(v6, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
